// File: rtl/preamble_sync_pkg.sv
// rtl/preamble_sync_pkg.sv - shared state encoding, default widths and helpers for the preamble sync sequencer
package preamble_sync_pkg;

  localparam int CNT_WIDTH_DEF  = 32;
  localparam int SETTLE_W_DEF   = 16;
  localparam int WIN_W_DEF      = 24;
  localparam int CLR_CYCLES_DEF = 4;
  localparam int STAT_W         = 32;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SETTLE,
    SEARCH,
    HOLDOFF
  } state_e;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sat_beat_counter.sv
// rtl/sat_beat_counter.sv - saturating beat counter; done_o flags the beat that completes len_i beats
module sat_beat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] len_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic [W:0]   nxt;

  assign nxt = {1'b0, cnt_q} + 1'b1;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A zero length is complete immediately, without waiting for a beat.
  assign done_o = (len_i == '0) || (en_i && !load_i && (nxt >= {1'b0, len_i}));

endmodule

// File: rtl/preamble_sync_ctrl.sv
// rtl/preamble_sync_ctrl.sv - arms, blanks and re-arms the preamble detector; qualifies and timestamps peaks
// Optional statistics outputs are built when PREAMBLE_SYNC_CTRL_STATS_EN is defined.
module preamble_sync_ctrl
  import preamble_sync_pkg::*;
#(
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int SETTLE_W   = SETTLE_W_DEF,
  parameter int WIN_W      = WIN_W_DEF,
  parameter int CLR_CYCLES = CLR_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 arm,
  input  logic                 abort,
  input  logic                 continuous,
  input  logic [SETTLE_W-1:0]  settle_len,
  input  logic [WIN_W-1:0]     search_len,
  input  logic [WIN_W-1:0]     holdoff_len,
  input  logic                 det_tvalid,
  input  logic                 det_peak_stb,
  output logic                 det_clear,
  output logic                 busy,
  output logic                 evt_valid,
  output logic [CNT_WIDTH-1:0] evt_time,
  output logic                 timeout
`ifdef PREAMBLE_SYNC_CTRL_STATS_EN
  ,
  output logic [STAT_W-1:0]    det_count,
  output logic [STAT_W-1:0]    timeout_count,
  output logic [STAT_W-1:0]    missed_count
`endif
);

  localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);

  state_e                state_q;
  logic [CLR_W-1:0]      clr_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [CNT_WIDTH-1:0]  cnt_d;
  logic [SETTLE_W-1:0]   cfg_settle_q;
  logic [WIN_W-1:0]      cfg_search_q;
  logic [WIN_W-1:0]      cfg_holdoff_q;
  logic                  cfg_cont_q;
  logic                  det_clear_q;
  logic                  busy_q;
  logic                  evt_valid_q;
  logic [CNT_WIDTH-1:0]  evt_time_q;
  logic                  timeout_q;

  logic settle_done;
  logic search_done_raw;
  logic holdoff_done;
  logic peak_hit;
  logic evt_fire;
  logic to_fire;
  logic seq_end;
  logic start;

  sat_beat_counter #(.W(SETTLE_W)) u_settle_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (state_q != SETTLE),
    .en_i    (det_tvalid && (state_q == SETTLE)),
    .len_i   (cfg_settle_q),
    .done_o  (settle_done)
  );

  sat_beat_counter #(.W(WIN_W)) u_search_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (state_q != SEARCH),
    .en_i    (det_tvalid && (state_q == SEARCH)),
    .len_i   (cfg_search_q),
    .done_o  (search_done_raw)
  );

  sat_beat_counter #(.W(WIN_W)) u_holdoff_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (state_q != HOLDOFF),
    .en_i    (det_tvalid && (state_q == HOLDOFF)),
    .len_i   (cfg_holdoff_q),
    .done_o  (holdoff_done)
  );

  // A zero search length means an unlimited window; a peak on the last beat beats the timeout.
  always_comb begin
    cnt_d    = det_tvalid ? cnt_q + 1'b1 : cnt_q;
    peak_hit = det_tvalid && det_peak_stb;
    evt_fire = !abort && (state_q == SEARCH) && peak_hit;
    to_fire  = !abort && (state_q == SEARCH) && !peak_hit &&
               (cfg_search_q != '0) && search_done_raw;
    seq_end  = to_fire || (!abort && (state_q == HOLDOFF) && holdoff_done);
    start    = !abort && (((state_q == IDLE) && arm) || (seq_end && cfg_cont_q));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      clr_q         <= '0;
      cnt_q         <= '0;
      cfg_settle_q  <= '0;
      cfg_search_q  <= '0;
      cfg_holdoff_q <= '0;
      cfg_cont_q    <= 1'b0;
      det_clear_q   <= 1'b0;
      busy_q        <= 1'b0;
      evt_valid_q   <= 1'b0;
      evt_time_q    <= '0;
      timeout_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      evt_valid_q <= evt_fire;
      timeout_q   <= to_fire;
      if (evt_fire) begin
        evt_time_q <= cnt_q;
      end
      if (abort) begin
        state_q     <= IDLE;
        det_clear_q <= 1'b0;
        busy_q      <= 1'b0;
      end else if (start) begin
        cfg_settle_q  <= settle_len;
        cfg_search_q  <= search_len;
        cfg_holdoff_q <= holdoff_len;
        cfg_cont_q    <= continuous;
        state_q       <= CLEAR;
        clr_q         <= '0;
        det_clear_q   <= 1'b1;
        busy_q        <= 1'b1;
      end else if (seq_end) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          CLEAR: begin
            if (clr_q == CLR_LAST) begin
              det_clear_q <= 1'b0;
              state_q     <= (cfg_settle_q == '0) ? SEARCH : SETTLE;
            end else begin
              clr_q <= clr_q + 1'b1;
            end
          end
          SETTLE: begin
            if (settle_done) begin
              state_q <= SEARCH;
            end
          end
          SEARCH: begin
            if (evt_fire) begin
              state_q <= HOLDOFF;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign det_clear = det_clear_q;
  assign busy      = busy_q;
  assign evt_valid = evt_valid_q;
  assign evt_time  = evt_time_q;
  assign timeout   = timeout_q;

`ifdef PREAMBLE_SYNC_CTRL_STATS_EN
  logic [STAT_W-1:0] det_cnt_q;
  logic [STAT_W-1:0] to_cnt_q;
  logic [STAT_W-1:0] miss_cnt_q;

  // Statistics survive abort; only reset_n clears them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      det_cnt_q  <= '0;
      to_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (evt_fire) begin
        det_cnt_q <= sat_inc(det_cnt_q);
      end
      if (to_fire) begin
        to_cnt_q <= sat_inc(to_cnt_q);
      end
      if ((state_q == HOLDOFF) && peak_hit) begin
        miss_cnt_q <= sat_inc(miss_cnt_q);
      end
    end
  end

  assign det_count     = det_cnt_q;
  assign timeout_count = to_cnt_q;
  assign missed_count  = miss_cnt_q;
`endif

endmodule

// File: tb/tb_preamble_sync_ctrl.sv
// tb/tb_preamble_sync_ctrl.sv - scoreboard bench for preamble_sync_ctrl
module tb_preamble_sync_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        arm;
  logic        abort;
  logic        continuous;
  logic [15:0] settle_len;
  logic [23:0] search_len;
  logic [23:0] holdoff_len;
  logic        det_tvalid;
  logic        det_peak_stb;
  logic        det_clear;
  logic        busy;
  logic        evt_valid;
  logic [31:0] evt_time;
  logic        timeout;
`ifdef PREAMBLE_SYNC_CTRL_STATS_EN
  logic [31:0] det_count;
  logic [31:0] timeout_count;
  logic [31:0] missed_count;
`endif

  int checks   = 0;
  int failures = 0;
  int beats    = 0;

  typedef struct {
    bit          is_evt;
    logic [31:0] t;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;

  always #5 clk = ~clk;

  preamble_sync_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .arm          (arm),
    .abort        (abort),
    .continuous   (continuous),
    .settle_len   (settle_len),
    .search_len   (search_len),
    .holdoff_len  (holdoff_len),
    .det_tvalid   (det_tvalid),
    .det_peak_stb (det_peak_stb),
    .det_clear    (det_clear),
    .busy         (busy),
    .evt_valid    (evt_valid),
    .evt_time     (evt_time),
    .timeout      (timeout)
`ifdef PREAMBLE_SYNC_CTRL_STATS_EN
    ,
    .det_count     (det_count),
    .timeout_count (timeout_count),
    .missed_count  (missed_count)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic cyc(input bit v, input bit p);
    det_tvalid   = v;
    det_peak_stb = p;
    @(posedge clk);
    #1;
    if (v && reset_n) beats++;
    det_tvalid   = 1'b0;
    det_peak_stb = 1'b0;
    arm          = 1'b0;
    abort        = 1'b0;
  endtask

  task automatic expect_evt();
    exp_q.push_back('{1'b1, beats});
  endtask

  task automatic expect_to();
    exp_q.push_back('{1'b0, 32'd0});
  endtask

  task automatic run_clear(input string name);
    int n = 0;
    while (det_clear && n < 20) begin
      n++;
      cyc(1'b0, 1'b0);
    end
    check(name, n, 4);
  endtask

  task automatic arm_seq(input int s, input int w, input int h, input bit c);
    settle_len  = 16'(s);
    search_len  = 24'(w);
    holdoff_len = 24'(h);
    continuous  = c;
    arm         = 1'b1;
    cyc(1'b0, 1'b0);
    check("busy_after_arm", busy, 1);
    run_clear("clear_len");
  endtask

  // Scoreboard monitor: every evt_valid/timeout pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (reset_n && (evt_valid || timeout)) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output evt_valid=%0b timeout=%0b required=none", evt_valid, timeout);
      end else begin
        e = exp_q.pop_front();
        check("out_evt_valid", {31'd0, evt_valid}, {31'd0, e.is_evt});
        check("out_timeout", {31'd0, timeout}, {31'd0, !e.is_evt});
        if (e.is_evt) check("evt_time", evt_time, e.t);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish required=finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; arm = 1'b0; abort = 1'b0; continuous = 1'b0;
    settle_len = '0; search_len = '0; holdoff_len = '0;
    det_tvalid = 1'b0; det_peak_stb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_det_clear", det_clear, 0);
    check("rst_busy", busy, 0);
    check("rst_evt_valid", evt_valid, 0);
    check("rst_timeout", timeout, 0);
    check("rst_evt_time", evt_time, 0);
    reset_n = 1'b1;
    cyc(1'b0, 1'b0);
    repeat (3) cyc(1'b1, 1'b0);

    // Settle 8 with a peak on beat 5 (ignored), accepted peak on beat 12.
    arm_seq(8, 0, 5, 1'b0);
    for (int i = 1; i <= 11; i++) cyc(1'b1, i == 5);
    expect_evt();
    cyc(1'b1, 1'b1);
    repeat (4) cyc(1'b1, 1'b0);
    check("busy_in_holdoff", busy, 1);
    cyc(1'b1, 1'b0);
    check("busy_after_holdoff", busy, 0);
    repeat (2) cyc(1'b0, 1'b0);
    check("evt_time_hold", evt_time, 14);

    // Continuous search timeouts, then abort that suppresses a coincident peak.
    arm_seq(2, 20, 3, 1'b1);
    repeat (2) cyc(1'b1, 1'b0);
    repeat (19) cyc(1'b1, 1'b0);
    expect_to();
    cyc(1'b1, 1'b0);
    run_clear("clear_rearm_len");
    repeat (2) cyc(1'b1, 1'b0);
    repeat (19) cyc(1'b1, 1'b0);
    expect_to();
    cyc(1'b1, 1'b0);
    run_clear("clear_rearm2_len");
    repeat (7) cyc(1'b1, 1'b0);
    abort = 1'b1;
    cyc(1'b1, 1'b1);
    check("abort_busy", busy, 0);
    check("abort_det_clear", det_clear, 0);
    check("abort_evt_valid", evt_valid, 0);
    check("abort_timeout", timeout, 0);
    cyc(1'b0, 1'b0);

    // Holdoff 10 with settle 0: peaks during holdoff and in the following CLEAR are ignored.
    arm_seq(0, 0, 10, 1'b1);
    expect_evt();
    cyc(1'b1, 1'b1);
    for (int k = 0; k <= 9; k++) begin
      cyc(1'b1, (k == 0) || (k == 3));
      if (k == 8) check("no_rearm_before_end", det_clear, 0);
    end
    check("rearm_after_holdoff", det_clear, 1);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
`ifdef PREAMBLE_SYNC_CTRL_STATS_EN
    check("det_count", det_count, 2);
    check("timeout_count", timeout_count, 2);
    check("missed_count", missed_count, 2);
`endif
    abort = 1'b1;
    cyc(1'b0, 1'b0);
    check("abort2_busy", busy, 0);

    // Peak on the final search beat wins over timeout; holdoff 0 exits next cycle.
    arm_seq(0, 20, 0, 1'b0);
    repeat (19) cyc(1'b1, 1'b0);
    expect_evt();
    cyc(1'b1, 1'b1);
    check("holdoff0_busy", busy, 1);
    cyc(1'b0, 1'b0);
    check("holdoff0_exit", busy, 0);
    repeat (2) cyc(1'b0, 1'b0);

    // Reset asserted mid-HOLDOFF, then a clean restart.
    arm_seq(0, 0, 10, 1'b0);
    expect_evt();
    cyc(1'b1, 1'b1);
    repeat (3) cyc(1'b1, 1'b0);
    #3;
    reset_n = 1'b0;
    #1;
    check("rst2_det_clear", det_clear, 0);
    check("rst2_busy", busy, 0);
    check("rst2_evt_valid", evt_valid, 0);
    check("rst2_timeout", timeout, 0);
    check("rst2_evt_time", evt_time, 0);
    beats = 0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (2) cyc(1'b1, 1'b0);
    arm_seq(3, 0, 2, 1'b0);
    repeat (3) cyc(1'b1, 1'b0);
    expect_evt();
    cyc(1'b1, 1'b1);
    repeat (2) cyc(1'b1, 1'b0);
    check("restart_idle", busy, 0);

    repeat (3) cyc(1'b0, 1'b0);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
